// File: rtl/serial_magnitude_compare.sv
// Multi-cycle MSB-first magnitude comparator: CHUNK bits per cycle with a gt/eq/lt cascade,
// signed/unsigned mode, optional early exit and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | comparing one chunk per edge, most significant chunk first
// DONE  | out_valid=1, result held until out_ready
module serial_magnitude_compare #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                is_signed,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_gt,
  output logic                                out_eq,
  output logic                                out_lt,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]    out_cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_gt_q, res_gt_d, res_eq_q, res_eq_d, res_lt_q, res_lt_d;
  logic [CW-1:0]     cyc_q, cyc_d;

  logic [CHUNK-1:0]  ca, cb;
  logic              gt_n, eq_n, lt_n, last;
  logic [CW-1:0]     cnt_n;

  // Operands shift left each RUN cycle, so the chunk under test is always the top one.
  // Only the first chunk holds the sign bit; flipping its MSB maps two's complement onto unsigned order.
  always_comb begin
    ca = a_q[WIDTH-1 -: CHUNK];
    cb = b_q[WIDTH-1 -: CHUNK];
    if (sgn_q && (cnt_q == '0)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  assign gt_n  = gt_q | (eq_q & (ca > cb));
  assign lt_n  = lt_q | (eq_q & (ca < cb));
  assign eq_n  = eq_q & (ca == cb);
  assign cnt_n = cnt_q + CW'(1);
  assign last  = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    cnt_d    = cnt_q;
    res_gt_d = res_gt_q;
    res_eq_d = res_eq_q;
    res_lt_d = res_lt_q;
    cyc_d    = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        gt_d  = gt_n;
        eq_d  = eq_n;
        lt_d  = lt_n;
        cnt_d = cnt_n;
        if (last || ((EARLY_EXIT != 0) && !eq_n)) begin
          res_gt_d = gt_n;
          res_eq_d = eq_n;
          res_lt_d = lt_n;
          cyc_d    = cnt_n;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      cnt_q    <= '0;
      res_gt_q <= 1'b0;
      res_eq_q <= 1'b0;
      res_lt_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      cnt_q    <= cnt_d;
      res_gt_q <= res_gt_d;
      res_eq_q <= res_eq_d;
      res_lt_q <= res_lt_d;
      cyc_q    <= cyc_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_gt     = res_gt_q;
  assign out_eq     = res_eq_q;
  assign out_lt     = res_lt_q;
  assign out_cycles = cyc_q;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench for serial_magnitude_compare: directed cases plus random operands
// checked against an arithmetic reference; a second instance runs with EARLY_EXIT=0.
module tb_serial_magnitude_compare;

  logic        clk;
  logic        rst_n;
  logic        in_valid, n_in_valid;
  logic        in_ready, n_in_ready;
  logic [31:0] a, b, n_a, n_b;
  logic        is_signed, n_is_signed;
  logic        out_valid, n_out_valid;
  logic        out_ready, n_out_ready;
  logic        out_gt, out_eq, out_lt, n_out_gt, n_out_eq, n_out_lt;
  logic [3:0]  out_cycles, n_out_cycles;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_magnitude_compare #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .out_cycles(out_cycles));

  serial_magnitude_compare #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(0)) u_dut_ne (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .is_signed(n_is_signed), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_gt(n_out_gt), .out_eq(n_out_eq), .out_lt(n_out_lt), .out_cycles(n_out_cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic compare, {gt,eq,lt}
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // Reference: chunks examined = position of the first differing nibble from the top
  function automatic int ref_cycles(input logic [31:0] x, input logic [31:0] y, input bit early);
    logic [31:0] d;
    d = x ^ y;
    if (!early) return 8;
    for (int i = 0; i < 8; i++)
      if (d[31-4*i -: 4] != 4'h0) return i + 1;
    return 8;
  endfunction

  // Runs one transaction on the selected instance; returns observed result and latency.
  task automatic do_txn(input bit ne, input logic [31:0] xa, input logic [31:0] xb, input logic s,
                        output logic [2:0] res, output int cyc, output int lat, output bit tmo);
    int w;
    tmo = 0;
    w = 0;
    while (!(ne ? n_in_ready : in_ready) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (ne) begin n_a = xa; n_b = xb; n_is_signed = s; n_in_valid = 1; n_out_ready = 0; end
    else    begin a = xa;   b = xb;   is_signed = s;   in_valid = 1;   out_ready = 0;   end
    @(posedge clk); #1;
    if (ne) n_in_valid = 0; else in_valid = 0;
    lat = 0;
    while (!(ne ? n_out_valid : out_valid) && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 50) tmo = 1;
    res = ne ? {n_out_gt, n_out_eq, n_out_lt} : {out_gt, out_eq, out_lt};
    cyc = ne ? int'(n_out_cycles) : int'(out_cycles);
    if (ne) n_out_ready = 1; else out_ready = 1;
    @(posedge clk); #1;
    if (ne) n_out_ready = 0; else out_ready = 0;
  endtask

  task automatic check_txn(input string name, input bit ne, input logic [31:0] xa,
                           input logic [31:0] xb, input logic s);
    logic [2:0] res, exp_res;
    int cyc, lat, exp_cyc;
    bit tmo;
    do_txn(ne, xa, xb, s, res, cyc, lat, tmo);
    exp_res = ref_cmp(xa, xb, s);
    exp_cyc = ref_cycles(xa, xb, !ne);
    total_cnt++;
    if (tmo) $display("FAIL %s timeout: out_valid never rose (a=%h b=%h)", name, xa, xb);
    else pass_cnt++;
    total_cnt++;
    if (res !== exp_res) $display("FAIL %s result a=%h b=%h s=%0d: got gt/eq/lt=%b want %b", name, xa, xb, s, res, exp_res);
    else pass_cnt++;
    total_cnt++;
    if (cyc != exp_cyc) $display("FAIL %s out_cycles a=%h b=%h: got %0d want %0d", name, xa, xb, cyc, exp_cyc);
    else pass_cnt++;
    total_cnt++;
    if (lat != exp_cyc) $display("FAIL %s latency a=%h b=%h: got %0d want %0d", name, xa, xb, lat, exp_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({in_ready, out_valid, out_gt, out_eq, out_lt, out_cycles} !== {1'b1, 1'b0, 3'b000, 4'd0})
      $display("FAIL reset_state: got rdy=%b vld=%b gel=%b%b%b cyc=%0d want rdy=1 vld=0 gel=000 cyc=0",
               in_ready, out_valid, out_gt, out_eq, out_lt, out_cycles);
    else pass_cnt++;
    total_cnt++;
    if ({n_in_ready, n_out_valid} !== 2'b10)
      $display("FAIL reset_state_ne: got rdy=%b vld=%b want 1 0", n_in_ready, n_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    check_txn("equal", 0, 32'h0000_00A5, 32'h0000_00A5, 0);
    check_txn("msb_unsigned", 0, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    check_txn("msb_signed", 0, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    check_txn("last_chunk", 0, 32'h1234_5679, 32'h1234_5678, 0);
    check_txn("no_early_exit", 1, 32'hF000_0000, 32'h0000_0000, 0);
    check_txn("signed_neg_eq", 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1);
    check_txn("signed_low", 0, 32'hFFFF_FFF1, 32'hFFFF_FFF0, 1);
  endtask

  task automatic test_random();
    logic [31:0] xa, xb;
    logic s;
    int k;
    for (int i = 0; i < 40; i++) begin
      xa = $urandom;
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: xb = $urandom;
        1: xb = xa;
        default: begin
          k  = $urandom_range(0, 7);
          xb = xa ^ (32'($urandom_range(1, 15)) << (4 * k));
        end
      endcase
      check_txn("random", (i % 4) == 3, xa, xb, s);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] held;
    logic [3:0] held_cyc;
    int w;
    bit stable_ok, rdy_ok;
    a = 32'h0000_0010; b = 32'h0000_0020; is_signed = 0; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (!out_valid) $display("FAIL bp_valid timeout: out_valid=%b want 1", out_valid);
    else pass_cnt++;
    held = {out_gt, out_eq, out_lt};
    held_cyc = out_cycles;
    total_cnt++;
    if (held !== 3'b001 || held_cyc !== 4'd7)
      $display("FAIL bp_result: got gel=%b cyc=%0d want 001 cyc=7", held, held_cyc);
    else pass_cnt++;
    a = 32'hFFFF_FFFF; b = 32'h0; in_valid = 1;
    stable_ok = 1; rdy_ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({out_valid, out_gt, out_eq, out_lt, out_cycles} !== {1'b1, held, held_cyc}) stable_ok = 0;
      if (in_ready !== 1'b0) rdy_ok = 0;
    end
    total_cnt++;
    if (!stable_ok) $display("FAIL bp_stable: got vld=%b gel=%b%b%b cyc=%0d want 1 %b %0d",
                             out_valid, out_gt, out_eq, out_lt, out_cycles, held, held_cyc);
    else pass_cnt++;
    total_cnt++;
    if (!rdy_ok) $display("FAIL bp_in_ready: got in_ready=1 during DONE want 0");
    else pass_cnt++;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if ({out_gt, out_eq, out_lt} !== held)
      $display("FAIL bp_idle_hold: got gel=%b%b%b want %b", out_gt, out_eq, out_lt, held);
    else pass_cnt++;
    repeat (3) begin @(posedge clk); #1; end
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_ignored_operands: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    bit no_valid;
    a = 32'h0; b = 32'h0; is_signed = 0; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL rst_mid_run: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    #3 rst_n = 1;
    no_valid = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) no_valid = 0;
    end
    out_ready = 0;
    total_cnt++;
    if (!no_valid) $display("FAIL rst_no_result: got out_valid=1 after abort want 0");
    else pass_cnt++;
    check_txn("after_reset", 0, 32'd3, 32'd5, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[$], qb[$];
    logic        qs[$];
    logic [2:0]  got[$];
    int          acc_t[$];
    int          ncyc[$];
    int          idx, cyc_now;
    bit          rdy_before;
    qa = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    qb = '{32'd5, 32'd1, 32'd1};
    qs = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      qa.push_back($urandom); qb.push_back($urandom); qs.push_back(1'($urandom_range(0, 1)));
    end
    idx = 0; cyc_now = 0;
    a = qa[0]; b = qb[0]; is_signed = qs[0]; in_valid = 1; out_ready = 1;
    while (got.size() < qa.size() && cyc_now < 500) begin
      rdy_before = in_ready;
      @(posedge clk); #1; cyc_now++;
      if (rdy_before && idx < qa.size()) begin
        acc_t.push_back(cyc_now);
        idx++;
        if (idx < qa.size()) begin a = qa[idx]; b = qb[idx]; is_signed = qs[idx]; end
        else in_valid = 0;
      end
      if (out_valid) got.push_back({out_gt, out_eq, out_lt});
    end
    in_valid = 0; out_ready = 0;
    total_cnt++;
    if (got.size() != qa.size()) $display("FAIL b2b_count: got %0d results want %0d", got.size(), qa.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < qa.size(); i++) begin
      total_cnt++;
      if (got[i] !== ref_cmp(qa[i], qb[i], qs[i]))
        $display("FAIL b2b_result[%0d]: got gel=%b want %b", i, got[i], ref_cmp(qa[i], qb[i], qs[i]));
      else pass_cnt++;
    end
    for (int i = 0; i < qa.size(); i++) ncyc.push_back(ref_cycles(qa[i], qb[i], 1));
    for (int i = 1; i < acc_t.size(); i++) begin
      total_cnt++;
      if (acc_t[i] - acc_t[i-1] != ncyc[i-1] + 2)
        $display("FAIL b2b_throughput[%0d]: got %0d cycles want %0d", i, acc_t[i] - acc_t[i-1], ncyc[i-1] + 2);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0; a = 0; b = 0; is_signed = 0; out_ready = 0;
    n_in_valid = 0; n_a = 0; n_b = 0; n_is_signed = 0; n_out_ready = 0;
    #22 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
